noise_sched: RTL and testbench

Sequencer that runs the channel noise source in programmed bursts. On `start` it warms up the source, then requests exactly `burst_len` valid samples per burst for `num_bursts` bursts, separated by `gap_len` idle cycles. It buffers captured samples in a 2-entry FIFO with a valid/ready output toward the channel adder. It sits between the Rx-sim control registers and the noise-source enable/sample interface.

---
 rtl/noise_sched.sv | 202 ++++++++++++++++++++
 tb/tb_noise_sched.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/noise_sched.sv
// Burst sequencer for the channel noise source with a 2-entry valid/ready output FIFO.
// Define NOISE_SCHED_STATS_EN to build the per-value sample statistics counters.
module noise_sched #(
    parameter int CNT_W  = 16,
    parameter int WARMUP = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic                    abort,
    input  logic [CNT_W-1:0]        burst_len,
    input  logic [CNT_W-1:0]        gap_len,
    input  logic [7:0]              num_bursts,
    output logic                    noise_en,
    input  logic signed [7:0]       noise_in,
    input  logic                    noise_in_valid,
    output logic signed [7:0]       out_sample,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        cnt_neg,
    output logic [CNT_W-1:0]        cnt_zero,
    output logic [CNT_W-1:0]        cnt_pos
);
    typedef enum logic [2:0] {S_IDLE, S_WARMUP, S_BURST, S_GAP, S_DRAIN, S_DONE} state_t;

    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP - 1);

    state_t            state_q, state_d;
    logic              en_q, en_d;
    logic              req_q, req_d;
    logic [CNT_W-1:0]  burst_len_q, burst_len_d;
    logic [CNT_W-1:0]  gap_len_q, gap_len_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  tmr_q, tmr_d;
    logic [7:0]        bursts_left_q, bursts_left_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic signed [7:0] mem_q [2];
    logic signed [7:0] mem_d [2];
    logic              pop;
    logic              push;
    logic [2:0]        credit;

    assign out_valid  = (cnt_q != 2'd0);
    assign out_sample = out_valid ? mem_q[rd_ptr_q] : '0;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign pop        = out_valid && out_ready;
    // req_q marks a request issued from BURST, so the warmup tail capture is discarded.
    assign push       = en_q && noise_in_valid && req_q && !abort;
    // Credit counts the same-cycle pop so a full-rate burst is not throttled.
    assign credit     = {1'b0, cnt_q} - {2'b00, pop} + {2'b00, req_q};

    always_comb begin
        // NOTE: every signal gets its hold value first so no path can infer a latch.
        state_d       = state_q;
        burst_len_d   = burst_len_q;
        gap_len_d     = gap_len_q;
        acc_d         = acc_q;
        tmr_d         = tmr_q;
        bursts_left_d = bursts_left_q;
        noise_en      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    burst_len_d   = burst_len;
                    gap_len_d     = gap_len;
                    bursts_left_d = num_bursts;
                    tmr_d         = '0;
                    state_d       = (num_bursts == 8'd0) ? S_DONE : S_WARMUP;
                end
            end
            S_WARMUP: begin
                noise_en = 1'b1;
                tmr_d    = tmr_q + 1'b1;
                if (tmr_q == WARM_LAST) begin
                    state_d = S_BURST;
                    acc_d   = '0;
                end
            end
            S_BURST: begin
                noise_en = (({1'b0, acc_q} + {{CNT_W{1'b0}}, req_q}) < {1'b0, burst_len_q})
                           && (credit < 3'd2);
                if (push) acc_d = acc_q + 1'b1;
                if ((acc_q == burst_len_q) && !req_q) begin
                    bursts_left_d = bursts_left_q - 8'd1;
                    acc_d         = '0;
                    tmr_d         = '0;
                    if (bursts_left_q == 8'd1)   state_d = S_DRAIN;
                    else if (gap_len_q != '0)    state_d = S_GAP;
                end
            end
            S_GAP: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == gap_len_q - 1'b1) begin
                    state_d = S_BURST;
                    acc_d   = '0;
                end
            end
            S_DRAIN: if (cnt_q == 2'd0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        mem_d    = mem_q;
        if (push) mem_d[wr_ptr_q] = noise_in;
        en_d  = noise_en;
        req_d = noise_en && (state_q == S_BURST);

        if (abort) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            en_d     = 1'b0;
            req_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            en_q          <= 1'b0;
            req_q         <= 1'b0;
            burst_len_q   <= '0;
            gap_len_q     <= '0;
            acc_q         <= '0;
            tmr_q         <= '0;
            bursts_left_q <= '0;
            cnt_q         <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            en_q          <= en_d;
            req_q         <= req_d;
            burst_len_q   <= burst_len_d;
            gap_len_q     <= gap_len_d;
            acc_q         <= acc_d;
            tmr_q         <= tmr_d;
            bursts_left_q <= bursts_left_d;
            cnt_q         <= cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // NOTE: FIFO storage needs no reset; out_sample is gated by out_valid instead.
    always_ff @(posedge clk) mem_q <= mem_d;

`ifdef NOISE_SCHED_STATS_EN
    logic [CNT_W-1:0] cnt_neg_q, cnt_neg_d;
    logic [CNT_W-1:0] cnt_zero_q, cnt_zero_d;
    logic [CNT_W-1:0] cnt_pos_q, cnt_pos_d;

    always_comb begin
        cnt_neg_d  = cnt_neg_q;
        cnt_zero_d = cnt_zero_q;
        cnt_pos_d  = cnt_pos_q;
        if ((state_q == S_IDLE) && start && !abort) begin
            cnt_neg_d  = '0;
            cnt_zero_d = '0;
            cnt_pos_d  = '0;
        end else if (push) begin
            case (noise_in)
                8'hFF:   if (cnt_neg_q  != '1) cnt_neg_d  = cnt_neg_q  + 1'b1;
                8'h00:   if (cnt_zero_q != '1) cnt_zero_d = cnt_zero_q + 1'b1;
                8'h01:   if (cnt_pos_q  != '1) cnt_pos_d  = cnt_pos_q  + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_neg_q  <= '0;
            cnt_zero_q <= '0;
            cnt_pos_q  <= '0;
        end else begin
            cnt_neg_q  <= cnt_neg_d;
            cnt_zero_q <= cnt_zero_d;
            cnt_pos_q  <= cnt_pos_d;
        end
    end

    assign cnt_neg  = cnt_neg_q;
    assign cnt_zero = cnt_zero_q;
    assign cnt_pos  = cnt_pos_q;
`else
    assign cnt_neg  = '0;
    assign cnt_zero = '0;
    assign cnt_pos  = '0;
`endif

endmodule

// File: tb/tb_noise_sched.sv
// Directed bench for noise_sched: the bench acts as the noise source and scoreboards
// every burst sample it hands over against what appears on the output port.
module tb_noise_sched;
    localparam int CNT_W  = 16;
    localparam int WARMUP = 4;

    logic                    clk = 1'b0;
    logic                    rstn;
    logic                    start;
    logic                    abort;
    logic [CNT_W-1:0]        burst_len;
    logic [CNT_W-1:0]        gap_len;
    logic [7:0]              num_bursts;
    logic                    noise_en;
    logic signed [7:0]       noise_in;
    logic                    noise_in_valid;
    logic signed [7:0]       out_sample;
    logic                    out_valid;
    logic                    out_ready;
    logic                    busy;
    logic                    done;
    logic [CNT_W-1:0]        cnt_neg;
    logic [CNT_W-1:0]        cnt_zero;
    logic [CNT_W-1:0]        cnt_pos;

    always #5 clk = ~clk;

    noise_sched #(.CNT_W(CNT_W), .WARMUP(WARMUP)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .start          (start),
        .abort          (abort),
        .burst_len      (burst_len),
        .gap_len        (gap_len),
        .num_bursts     (num_bursts),
        .noise_en       (noise_en),
        .noise_in       (noise_in),
        .noise_in_valid (noise_in_valid),
        .out_sample     (out_sample),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .busy           (busy),
        .done           (done),
        .cnt_neg        (cnt_neg),
        .cnt_zero       (cnt_zero),
        .cnt_pos        (cnt_pos)
    );

    int total = 0;
    int bad   = 0;

    logic signed [7:0] sb [$];
    logic signed [7:0] list_vals [5];
    int  cyc;
    int  mode;          // 0: always-valid source, 1: drop replies 2 and 4, 2: list values
    bit  sb_on;
    bit  chk_main;
    int  beats, dones, en_cnt, burst_reqs, done_cyc, vcnt;
    bit  prev_en, prev_burst;
    int  prev_req;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One clock cycle: answer last cycle's request, observe outputs, advance to posedge+1.
    task automatic step();
        logic signed [7:0] v;
        bit                ok_reply;
        case (vcnt % 3)
            0:       v = -8'sd1;
            1:       v = 8'sd0;
            default: v = 8'sd1;
        endcase
        vcnt++;
        ok_reply = 1'b1;
        if (prev_burst) begin
            if (mode == 1 && (prev_req == 2 || prev_req == 4)) ok_reply = 1'b0;
            if (mode == 2) v = list_vals[(prev_req - 1) % 5];
        end
        case (mode)
            0:       noise_in_valid = 1'b1;
            1:       noise_in_valid = prev_en && ok_reply;
            default: noise_in_valid = prev_burst;
        endcase
        noise_in = v;
        if (sb_on && prev_burst && noise_in_valid) sb.push_back(v);
        #2;
        if (out_valid && out_ready) begin
            beats++;
            check("beat_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) check("sample", 32'(out_sample), 32'(sb.pop_front()));
        end
        if (chk_main) begin
            check("noise_en_cycle", 32'(noise_en), 32'((cyc >= 1 && cyc <= 9) || (cyc >= 15 && cyc <= 19)));
            check("busy_cycle", 32'(busy), 32'(cyc >= 1 && cyc <= 23));
            check("done_cycle", 32'(done), 32'(cyc == 23));
        end
        if (done) begin
            dones++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        if (noise_en) en_cnt++;
        prev_burst = noise_en && (cyc >= WARMUP + 1);
        if (prev_burst) begin
            burst_reqs++;
            prev_req = burst_reqs;
        end
        prev_en = noise_en;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int bl, input int gl, input int nb);
        burst_len  = CNT_W'(bl);
        gap_len    = CNT_W'(gl);
        num_bursts = 8'(nb);
        cyc = 0; beats = 0; dones = 0; en_cnt = 0; burst_reqs = 0; done_cyc = -1;
        sb.delete();
        sb_on = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input bit toggle_ready);
        int n;
        n = 0;
        while (dones == 0 && n < limit) begin
            if (toggle_ready) out_ready = cyc[0];
            step();
            n++;
        end
        check("done_within_bound", 32'(dones > 0), 32'd1);
    endtask

    initial begin
        list_vals = '{8'sd0, 8'sd0, 8'sd0, 8'sd1, -8'sd1};
        rstn = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        burst_len = '0; gap_len = '0; num_bursts = '0;
        noise_in = '0; noise_in_valid = 1'b0;
        mode = 0; sb_on = 1'b0; chk_main = 1'b0; vcnt = 0;
        prev_en = 1'b0; prev_burst = 1'b0; prev_req = 0;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_noise_en", 32'(noise_en), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out_sample", 32'(out_sample), 32'd0);
        check("rst_cnt_sum", 32'(cnt_neg) + 32'(cnt_zero) + 32'(cnt_pos), 32'd0);
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk);
        #1;

        // Two bursts of 5 with a gap of 3, full-rate drain: exact cycle timing.
        chk_main = 1'b1;
        start_run(5, 3, 2);
        repeat (25) step();
        chk_main = 1'b0;
        check("main_beats", beats, 10);
        check("main_dones", dones, 1);
        check("main_sb_empty", sb.size(), 0);

        // Same run with out_ready toggling: no sample lost or duplicated.
        start_run(5, 3, 2);
        wait_done(200, 1'b1);
        out_ready = 1'b1;
        step();
        check("toggle_beats", beats, 10);
        check("toggle_dones", dones, 1);
        check("toggle_sb_empty", sb.size(), 0);

        // Source drops 2 of the burst replies: 7 requests yield exactly 5 samples.
        mode = 1;
        start_run(5, 0, 1);
        wait_done(100, 1'b0);
        step();
        check("drop_requests", burst_reqs, 7);
        check("drop_beats", beats, 5);
        check("drop_sb_empty", sb.size(), 0);
        mode = 0;

        // Abort on the 3rd BURST cycle: everything drops the next cycle, no done.
        start_run(5, 3, 2);
        repeat (WARMUP + 2) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        sb.delete();
        sb_on = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_noise_en", 32'(noise_en), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (6) step();
        check("abort_no_done", dones, 0);

        // Reset asserted mid-burst: outputs return to 0 at once.
        start_run(5, 3, 2);
        repeat (WARMUP + 2) step();
        check("pre_reset_busy", 32'(busy), 32'd1);
        rstn = 1'b0;
        #2;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_noise_en", 32'(noise_en), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_sample", 32'(out_sample), 32'd0);
        @(posedge clk);
        #3 rstn = 1'b1;
        #1;
        check("postrst_busy", 32'(busy), 32'd0);
        check("postrst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        sb.delete();
        prev_en = 1'b0;
        prev_burst = 1'b0;

        // Zero bursts: straight to done, source never enabled.
        start_run(5, 3, 0);
        repeat (4) step();
        check("zero_noise_en_cycles", en_cnt, 0);
        check("zero_dones", dones, 1);
        check("zero_done_window", 32'(done_cyc >= 1 && done_cyc <= 2), 32'd1);
        check("zero_busy_after", 32'(busy), 32'd0);

        // Statistics: burst stream 0,0,0,+1,-1.
        mode = 2;
        start_run(5, 3, 1);
        wait_done(100, 1'b0);
        step();
        check("stats_beats", beats, 5);
`ifdef NOISE_SCHED_STATS_EN
        check("stats_zero", 32'(cnt_zero), 32'd3);
        check("stats_pos", 32'(cnt_pos), 32'd1);
        check("stats_neg", 32'(cnt_neg), 32'd1);
`else
        check("stats_zero", 32'(cnt_zero), 32'd0);
        check("stats_pos", 32'(cnt_pos), 32'd0);
        check("stats_neg", 32'(cnt_neg), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
